pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game sequencer for the pong design. Sits between the sync generator, the paddle/ball datapath and the score display: it counts frames from `vsync`, walks the match through idle, serve, play, point pause and game-over, and keeps both players' scores. Its outputs start and stop ball motion, recenter the ball, set serve direction and report score and state. It contains no pixel logic.

## Interface
Parameters:
- `WIN_SCORE`, 11: score that ends the match (1–15). Used only with the win limit compiled in.
- `SERVE_FRAMES`, 60: frames held in SERVE before the ball moves (1–255).
- `POINT_FRAMES`, 90: frames held in POINT after a score (1–255).
- `VSYNC_ACTIVE_LOW`, 1: polarity of `vsync`. 1 means the pulse is low.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vsync`  in  1  vertical sync from the sync generator, same clock domain.
- `start`  in  1  start button, level. Only its rising edge is used.
- `miss_l`  in  1  ball left through the left edge; player 2 scores.
- `miss_r`  in  1  ball left through the right edge; player 1 scores.
- `ball_run`  out  1  ball may move. High only in PLAY.
- `ball_load`  out  1  one-cycle pulse: recenter the ball.
- `serve_dir`  out  1  serve direction. 0 = toward the left paddle, 1 = toward the right paddle.
- `score1`, `score2`  out  4 each  player scores.
- `game_over`  out  1  high in OVER.
- `state`  out  3  state code, for debug.

## Operation
- Frame tick: an internal one-cycle pulse, the cycle after `vsync` goes from inactive to active. The previous-`vsync` register resets to the inactive level.
- Start edge: `start` high with the previous sample low. The previous-`start` register resets to 1, so a button held through reset does not fire.
- One 8-bit frame counter. It decrements on each frame tick and the state advances on the tick that brings it to 0. A load of N therefore gives exactly N ticks.

State codes and transitions:
- IDLE=0: scores held at 0. A start edge goes to SERVE, loads the counter with SERVE_FRAMES and sets `serve_dir`=0.
- SERVE=1: when the counter expires, go to PLAY.
- PLAY=2: misses are sampled every cycle.
  - `miss_r` alone: `score1`+1, `serve_dir`<=1.
  - `miss_l` alone: `score2`+1, `serve_dir`<=0.
  - Both in the same cycle: no score change, `serve_dir` unchanged.
  - Any miss goes to POINT and loads the counter with POINT_FRAMES.
- POINT=3: misses are ignored. On expiry, go to OVER if the win limit is met (see Configuration), otherwise go to SERVE and load SERVE_FRAMES.
- OVER=4: scores are frozen. A start edge clears both scores, sets `serve_dir`=0, goes to SERVE and loads SERVE_FRAMES.
- Start edges are ignored in SERVE, PLAY and POINT. Codes 5–7 return to IDLE on the next cycle.

Output decode:
- `ball_load` is high during exactly the first cycle of every SERVE entry.
- `ball_run` = (state==PLAY).
- `game_over` = (state==OVER).
- All outputs are registered.

## Timing
- Every output resets to 0: state IDLE, counter 0, both scores 0, `ball_run`, `ball_load`, `serve_dir`, `game_over`.
- Asserting `rst_n` mid-operation clears everything immediately, with no dependence on the clock. The first start edge after release is honoured.
- `miss_*` to score update and PLAY→POINT: 1 clock. `ball_run` falls in that same cycle.
- Start edge to SERVE and `ball_load`: 1 clock after the sampled edge.
- SERVE to PLAY: the SERVE_FRAMES-th frame tick after entry. `ball_run` rises on the following cycle.
- A frame tick in the same cycle as a miss: the miss wins, and the counter loads POINT_FRAMES.

## Configuration
- `PONG_CTRL_WIN_LIMIT_EN` defined:
  - POINT expiry goes to OVER when `score1`==WIN_SCORE or `score2`==WIN_SCORE.
  - Scores never exceed WIN_SCORE.
- Undefined:
  - OVER is unreachable and `game_over` stays 0.
  - Scores wrap 15→0.
  - POINT always returns to SERVE.

## Test plan
Bench parameters: SERVE_FRAMES=2, POINT_FRAMES=3, WIN_SCORE=3, short frames.
- Reset with `start` held high, then release reset -> stays IDLE, all outputs 0. Drop `start` and raise it -> SERVE, `ball_load` high for 1 cycle, `serve_dir`=0. After 2 frame ticks -> PLAY and `ball_run`=1.
- In PLAY, pulse `miss_r` -> next cycle `score1`=1, `serve_dir`=1, `ball_run`=0, state=3. After 3 ticks -> SERVE with a `ball_load` pulse.
- In PLAY, assert `miss_l` and `miss_r` together -> scores unchanged, state POINT. A frame tick in the same cycle as a miss -> POINT lasts a full 3 ticks.
- With the macro defined, player 2 scores 3 times -> `score2`=3, then OVER with `game_over`=1. `start` in OVER -> scores 0 and SERVE. Without the macro, 16 player-1 points -> `score1` wraps to 0 and `game_over` never asserts.
- Assert `rst_n` low mid-PLAY with scores 2/1 -> all outputs 0 with no clock edge. `start` edges during SERVE, PLAY and POINT are ignored.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: frame-counted serve/point pauses, miss scoring and registered status outputs.
// Optional win limit (POINT expiry can end the match in OVER) compiled in with PONG_CTRL_WIN_LIMIT_EN.
module pong_game_ctrl #(
    parameter int WIN_SCORE        = 11,
    parameter int SERVE_FRAMES     = 60,
    parameter int POINT_FRAMES     = 90,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       start,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       ball_run,
    output logic       ball_load,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic       VS_INACT = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [7:0] SF       = 8'(SERVE_FRAMES);
    localparam logic [7:0] PF       = 8'(POINT_FRAMES);
`ifdef PONG_CTRL_WIN_LIMIT_EN
    localparam logic [3:0] WIN      = 4'(WIN_SCORE);
`endif

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] s1_q, s1_d, s2_q, s2_d;
    logic       dir_q, dir_d;
    logic       vsync_q, start_q, tick_q;
    logic       vs_act, vs_prev_act, start_edge, expire, win_hit;

    assign vs_act      = VSYNC_ACTIVE_LOW ? ~vsync   : vsync;
    assign vs_prev_act = VSYNC_ACTIVE_LOW ? ~vsync_q : vsync_q;
    assign start_edge  = start & ~start_q;
    // Advance on the tick that takes the counter from 1 to 0, so a load of N is N ticks.
    assign expire      = tick_q && (cnt_q == 8'd1);

`ifdef PONG_CTRL_WIN_LIMIT_EN
    assign win_hit = (s1_q == WIN) || (s2_q == WIN);

    function automatic logic [3:0] bump(input logic [3:0] s);
        return (s == WIN) ? s : s + 4'd1;
    endfunction
`else
    assign win_hit = 1'b0;

    function automatic logic [3:0] bump(input logic [3:0] s);
        return s + 4'd1;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dir_d   = dir_q;
        if (tick_q && cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
        case (state_q)
            IDLE: begin
                s1_d = 4'd0;
                s2_d = 4'd0;
                if (start_edge) begin
                    state_d = SERVE;
                    cnt_d   = SF;
                    dir_d   = 1'b0;
                end
            end
            SERVE: if (expire) state_d = PLAY;
            PLAY: begin
                // A miss beats a coincident frame tick: the full point pause is loaded.
                if (miss_l || miss_r) begin
                    state_d = POINT;
                    cnt_d   = PF;
                    if (miss_r && !miss_l) begin
                        s1_d  = bump(s1_q);
                        dir_d = 1'b1;
                    end else if (miss_l && !miss_r) begin
                        s2_d  = bump(s2_q);
                        dir_d = 1'b0;
                    end
                end
            end
            POINT: begin
                if (expire) begin
                    if (win_hit) begin
                        state_d = OVER;
                    end else begin
                        state_d = SERVE;
                        cnt_d   = SF;
                    end
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_d = SERVE;
                    cnt_d   = SF;
                    s1_d    = 4'd0;
                    s2_d    = 4'd0;
                    dir_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= VS_INACT;
            start_q   <= 1'b1;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            s1_q      <= 4'd0;
            s2_q      <= 4'd0;
            dir_q     <= 1'b0;
            ball_run  <= 1'b0;
            ball_load <= 1'b0;
            game_over <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            start_q   <= start;
            tick_q    <= vs_act & ~vs_prev_act;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            dir_q     <= dir_d;
            ball_run  <= (state_d == PLAY);
            ball_load <= (state_d == SERVE) && (state_q != SERVE);
            game_over <= (state_d == OVER);
        end
    end

    assign state     = state_q;
    assign score1    = s1_q;
    assign score2    = s2_q;
    assign serve_dir = dir_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with short serve/point pauses; follows PONG_CTRL_WIN_LIMIT_EN if defined.
module tb_pong_game_ctrl;

    localparam int SF = 2;
    localparam int PF = 3;
    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       rst_n, vsync, start, miss_l, miss_r;
    logic       ball_run, ball_load, serve_dir, game_over;
    logic [3:0] score1, score2;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int loads = 0;
    int overs = 0;

    pong_game_ctrl #(
        .WIN_SCORE(WS), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .start(start),
        .miss_l(miss_l), .miss_r(miss_r), .ball_run(ball_run), .ball_load(ball_load),
        .serve_dir(serve_dir), .score1(score1), .score2(score2),
        .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ball_load === 1'b1) loads <= loads + 1;
        if (game_over === 1'b1) overs <= overs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One active-low vsync pulse followed by settling cycles.
    task automatic frames(input int n);
        repeat (n) begin
            vsync = 1'b0;
            cyc(2);
            vsync = 1'b1;
            cyc(3);
        end
    endtask

    task automatic press();
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic point(input logic l, input logic r);
        miss_l = l;
        miss_r = r;
        cyc();
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_s1"}, score1, 0);
        chk({tag, "_s2"}, score2, 0);
        chk({tag, "_run"}, ball_run, 0);
        chk({tag, "_load"}, ball_load, 0);
        chk({tag, "_dir"}, serve_dir, 0);
        chk({tag, "_over"}, game_over, 0);
    endtask

    initial begin
        int l0;
        rst_n = 1'b0; vsync = 1'b1; start = 1'b1; miss_l = 1'b0; miss_r = 1'b0;
        cyc(3);
        check_zero("rst");
        rst_n = 1'b1;
        cyc(3);
        chk("held_start_idle", state, 0);
        chk("held_start_load", ball_load, 0);

        // Start edge -> SERVE with one-cycle load pulse.
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        chk("start_state", state, 1);
        chk("start_load", ball_load, 1);
        chk("start_dir", serve_dir, 0);
        cyc();
        chk("load_drop", ball_load, 0);
        start = 1'b0;
        frames(1);
        chk("serve_1tick", state, 1);
        chk("serve_1tick_run", ball_run, 0);
        frames(1);
        chk("play_state", state, 2);
        chk("play_run", ball_run, 1);

        // Right miss: player 1 scores.
        point(1'b0, 1'b1);
        chk("missr_s1", score1, 1);
        chk("missr_dir", serve_dir, 1);
        chk("missr_run", ball_run, 0);
        chk("missr_state", state, 3);
        l0 = loads;
        frames(PF - 1);
        chk("point_hold", state, 3);
        frames(1);
        chk("point_serve", state, 1);
        chk("point_load_cnt", loads - l0, 1);
        frames(SF);
        chk("replay", state, 2);

        // Simultaneous misses: no score, direction kept.
        point(1'b1, 1'b1);
        chk("both_state", state, 3);
        chk("both_s1", score1, 1);
        chk("both_s2", score2, 0);
        chk("both_dir", serve_dir, 1);
        frames(PF);
        frames(SF);
        chk("both_replay", state, 2);

        // Frame tick coincident with a miss: full point pause still follows.
        vsync = 1'b0;
        cyc();
        miss_l = 1'b1;
        cyc();
        miss_l = 1'b0;
        vsync = 1'b1;
        cyc(3);
        chk("tickmiss_state", state, 3);
        chk("tickmiss_s2", score2, 1);
        chk("tickmiss_dir", serve_dir, 0);
        frames(PF - 1);
        chk("tickmiss_hold", state, 3);
        frames(1);
        chk("tickmiss_serve", state, 1);
        frames(SF);

        // Start ignored in PLAY, POINT and SERVE.
        press();
        chk("ign_play", state, 2);
        point(1'b1, 1'b0);
        chk("s2_two", score2, 2);
        press();
        chk("ign_point", state, 3);
        frames(PF);
        press();
        chk("ign_serve", state, 1);
        frames(SF);
        chk("ign_serve_play", state, 2);
        point(1'b1, 1'b0);
        chk("s2_three", score2, 3);
        frames(PF);
`ifdef PONG_CTRL_WIN_LIMIT_EN
        chk("win_state", state, 4);
        chk("win_over", game_over, 1);
        chk("win_run", ball_run, 0);
        press();
        chk("restart_state", state, 1);
        chk("restart_s1", score1, 0);
        chk("restart_s2", score2, 0);
        chk("restart_dir", serve_dir, 0);
        chk("restart_over", game_over, 0);
`else
        chk("nowin_state", state, 1);
        chk("nowin_over", game_over, 0);
        frames(SF);
        // score1 is 1; fifteen more points wrap it through 15 to 0.
        repeat (15) begin
            point(1'b0, 1'b1);
            frames(PF);
            frames(SF);
        end
        chk("wrap_s1", score1, 0);
        chk("wrap_state", state, 2);
        chk("wrap_never_over", overs, 0);
`endif

        // Fresh match to 2/1 in PLAY, then asynchronous reset.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        press();
        chk("rst2_start", state, 1);
        frames(SF);
        point(1'b0, 1'b1); frames(PF); frames(SF);
        point(1'b0, 1'b1); frames(PF); frames(SF);
        point(1'b1, 1'b0); frames(PF); frames(SF);
        chk("pre_s1", score1, 2);
        chk("pre_s2", score2, 1);
        chk("pre_state", state, 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_zero("async");
        cyc();
        rst_n = 1'b1;
        cyc();
        press();
        chk("post_rst_start", state, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
